// File: rtl/fwd_pkg.sv
// Shared types for the result-side forwarding pipe: widths, select codes,
// the per-stage record and the operand select helper.
package fwd_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Select codes returned by the forwarding unit for each EX operand.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10,
    FWD_T  = 2'b11
  } fwd_sel_e;

  // One retiring instruction as seen by the forwarding network.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic [XLEN-1:0]   data;
  } stage_t;

  // Operand select shared by the A and B paths.
  function automatic logic [XLEN-1:0] fwd_mux(
    input fwd_sel_e        sel,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] m,
    input logic [XLEN-1:0] w,
    input logic [XLEN-1:0] t
  );
    logic [XLEN-1:0] y;
    y = rf;
    case (sel)
      FWD_RF: y = rf;
      FWD_M:  y = m;
      FWD_W:  y = w;
      FWD_T:  y = t;
      default: y = rf;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One retiring-stage register {rd, wr_en, data} with load enable, bubble
// clear and async reset. The optional is_load bit is only kept in M.
module fwd_stage_reg #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter bit HAS_LOAD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic              clr,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_wr_en,
  input  logic [XLEN-1:0]   d_data,
  input  logic              d_is_load,
  output logic [REG_AW-1:0] q_rd,
  output logic              q_wr_en,
  output logic [XLEN-1:0]   q_data,
  output logic              q_is_load
);

  logic [REG_AW-1:0] rd_d, rd_q;
  logic              wr_en_d, wr_en_q;
  logic [XLEN-1:0]   data_d, data_q;
  logic              is_load_d, is_load_q;
  logic              is_load_in;

  // Stages without a load flag tie it off so the flop folds away.
  generate
    if (HAS_LOAD) begin : g_ld
      assign is_load_in = d_is_load;
    end else begin : g_no_ld
      logic unused_is_load;
      assign unused_is_load = d_is_load;
      assign is_load_in     = 1'b0;
    end
  endgenerate

  // Hold by default, load on ld; clr wins for the control fields so a
  // bubble lands even while the pipe is stalled. Data is left as-is.
  always_comb begin
    rd_d      = rd_q;
    wr_en_d   = wr_en_q;
    data_d    = data_q;
    is_load_d = is_load_q;
    if (ld) begin
      rd_d      = d_rd;
      wr_en_d   = d_wr_en;
      data_d    = d_data;
      is_load_d = is_load_in;
    end
    if (clr) begin
      rd_d      = '0;
      wr_en_d   = 1'b0;
      is_load_d = 1'b0;
    end
  end

  // Stage state; reset leaves a clean bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      is_load_q <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      is_load_q <= is_load_d;
    end
  end

  assign q_rd      = rd_q;
  assign q_wr_en   = wr_en_q;
  assign q_data    = data_q;
  assign q_is_load = is_load_q;

endmodule

// File: rtl/fwd_result_pipe.sv
// M/W/T result pipe feeding the EX forwarding unit: holds the three retiring
// instructions, applies the forwarding selects to the EX operands and drives
// the register-file write port from W. Widths follow fwd_pkg.
module fwd_result_pipe
  import fwd_pkg::*;
#(
  parameter int XLEN   = fwd_pkg::XLEN,
  parameter int REG_AW = fwd_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance_en,
  input  logic              flush_m,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_reg_wr_en,
  input  logic              ex_is_load,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic [XLEN-1:0]   rs1_data_e,
  input  logic [XLEN-1:0]   rs2_data_e,
  input  logic [1:0]        fowardAE,
  input  logic [1:0]        fowardBE,
  output logic [REG_AW-1:0] rdm_addr,
  output logic [REG_AW-1:0] rdw_addr,
  output logic [REG_AW-1:0] rdt_addr,
  output logic              regwrite_m,
  output logic              regwrite_w,
  output logic              regwrite_t,
  output logic [XLEN-1:0]   operand_a,
  output logic [XLEN-1:0]   operand_b,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [XLEN-1:0]   rf_wr_data
);

  stage_t          m_st, w_st, t_st;
  logic            m_is_load;
  logic            w_is_load_unused, t_is_load_unused;
  logic            ex_wr_en;
  logic [XLEN-1:0] m_result;

  // x0 writes are dropped at capture so nothing downstream ever forwards x0.
  assign ex_wr_en = ex_reg_wr_en & (ex_rd_addr != '0);

  // A load carries its address through M; the loaded word replaces it on M->W.
  always_comb begin
    m_result = m_st.data;
    if (m_is_load) m_result = dmem_rdata;
  end

  fwd_stage_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .HAS_LOAD(1'b1)) u_m (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld        (advance_en),
    .clr       (flush_m),
    .d_rd      (ex_rd_addr),
    .d_wr_en   (ex_wr_en),
    .d_data    (ex_alu_result),
    .d_is_load (ex_is_load),
    .q_rd      (m_st.rd),
    .q_wr_en   (m_st.wr_en),
    .q_data    (m_st.data),
    .q_is_load (m_is_load)
  );

  fwd_stage_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .HAS_LOAD(1'b0)) u_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld        (advance_en),
    .clr       (1'b0),
    .d_rd      (m_st.rd),
    .d_wr_en   (m_st.wr_en),
    .d_data    (m_result),
    .d_is_load (1'b0),
    .q_rd      (w_st.rd),
    .q_wr_en   (w_st.wr_en),
    .q_data    (w_st.data),
    .q_is_load (w_is_load_unused)
  );

  // T keeps the instruction forwardable one cycle past the RF write.
  fwd_stage_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .HAS_LOAD(1'b0)) u_t (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld        (advance_en),
    .clr       (1'b0),
    .d_rd      (w_st.rd),
    .d_wr_en   (w_st.wr_en),
    .d_data    (w_st.data),
    .d_is_load (1'b0),
    .q_rd      (t_st.rd),
    .q_wr_en   (t_st.wr_en),
    .q_data    (t_st.data),
    .q_is_load (t_is_load_unused)
  );

  // Operand muxes: index 0 is A, index 1 is B.
  logic [1:0][1:0]      sel;
  logic [1:0][XLEN-1:0] rf_op;
  logic [1:0][XLEN-1:0] fwd_op;

  assign sel   = {fowardBE, fowardAE};
  assign rf_op = {rs2_data_e, rs1_data_e};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_op
      assign fwd_op[i] = fwd_mux(fwd_sel_e'(sel[i]), rf_op[i],
                                 m_st.data, w_st.data, t_st.data);
    end
  endgenerate

  assign operand_a  = fwd_op[0];
  assign operand_b  = fwd_op[1];

  assign rdm_addr   = m_st.rd;
  assign rdw_addr   = w_st.rd;
  assign rdt_addr   = t_st.rd;
  assign regwrite_m = m_st.wr_en;
  assign regwrite_w = w_st.wr_en;
  assign regwrite_t = t_st.wr_en;

  assign rf_wr_en   = w_st.wr_en;
  assign rf_wr_addr = w_st.rd;
  assign rf_wr_data = w_st.data;

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Directed bench for fwd_result_pipe with a retire scoreboard: every
// captured register write is queued and checked when it reaches W.
module tb_fwd_result_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        advance_en, flush_m;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_wr_en, ex_is_load;
  logic [31:0] ex_alu_result, dmem_rdata, rs1_data_e, rs2_data_e;
  logic [1:0]  fowardAE, fowardBE;
  logic [4:0]  rdm_addr, rdw_addr, rdt_addr;
  logic        regwrite_m, regwrite_w, regwrite_t;
  logic [31:0] operand_a, operand_b;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  fwd_result_pipe dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance_en    (advance_en),
    .flush_m       (flush_m),
    .ex_rd_addr    (ex_rd_addr),
    .ex_reg_wr_en  (ex_reg_wr_en),
    .ex_is_load    (ex_is_load),
    .ex_alu_result (ex_alu_result),
    .dmem_rdata    (dmem_rdata),
    .rs1_data_e    (rs1_data_e),
    .rs2_data_e    (rs2_data_e),
    .fowardAE      (fowardAE),
    .fowardBE      (fowardBE),
    .rdm_addr      (rdm_addr),
    .rdw_addr      (rdw_addr),
    .rdt_addr      (rdt_addr),
    .regwrite_m    (regwrite_m),
    .regwrite_w    (regwrite_w),
    .regwrite_t    (regwrite_t),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_data    (rf_wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [31:0] alu);
    ex_rd_addr    = rd;
    ex_reg_wr_en  = we;
    ex_is_load    = ld;
    ex_alu_result = alu;
  endtask

  // One clock: note what the edge will capture, then retire-check W.
  task automatic tick();
    logic adv, cap;
    sb_t  e, r;
    adv    = advance_en && rst_n;
    cap    = adv && !flush_m && ex_reg_wr_en && (ex_rd_addr != 5'd0);
    e.addr = ex_rd_addr;
    e.data = ex_is_load ? dmem_rdata : ex_alu_result;
    @(posedge clk);
    #1;
    if (adv && rf_wr_en) begin
      if (sb.size() == 0) begin
        chk("rf_wr_en_unexpected", {31'd0, rf_wr_en}, 32'd0);
      end else begin
        r = sb.pop_front();
        chk("sb_rf_wr_addr", {27'd0, rf_wr_addr}, {27'd0, r.addr});
        chk("sb_rf_wr_data", rf_wr_data, r.data);
      end
    end
    if (cap) sb.push_back(e);
  endtask

  initial begin
    rst_n      = 1'b0;
    advance_en = 1'b1;
    flush_m    = 1'b0;
    dmem_rdata = 32'h0;
    rs1_data_e = 32'h1111_0000;
    rs2_data_e = 32'h0000_ABCD;
    fowardAE   = 2'b00;
    fowardBE   = 2'b00;
    issue(5'd5, 1'b1, 1'b0, 32'h55);

    // reset held with a live EX write
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("rst_regwrite_w", {31'd0, regwrite_w}, 32'd0);
    chk("rst_regwrite_t", {31'd0, regwrite_t}, 32'd0);
    chk("rst_rdm_addr", {27'd0, rdm_addr}, 32'd0);
    chk("rst_rdw_addr", {27'd0, rdw_addr}, 32'd0);
    chk("rst_rdt_addr", {27'd0, rdt_addr}, 32'd0);
    chk("rst_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);

    // ALU chain x3, x4, x5
    issue(5'd3, 1'b1, 1'b0, 32'h11); tick();
    chk("chain_rdm_x3", {27'd0, rdm_addr}, 32'd3);
    chk("chain_regwrite_m", {31'd0, regwrite_m}, 32'd1);
    issue(5'd4, 1'b1, 1'b0, 32'h22); tick();
    chk("chain_rf_wr_en_x3", {31'd0, rf_wr_en}, 32'd1);
    chk("chain_rf_wr_data_x3", rf_wr_data, 32'h11);
    issue(5'd5, 1'b1, 1'b0, 32'h33); tick();
    issue(5'd0, 1'b0, 1'b0, 32'h0);
    chk("chain_rdm", {27'd0, rdm_addr}, 32'd5);
    chk("chain_rdw", {27'd0, rdw_addr}, 32'd4);
    chk("chain_rdt", {27'd0, rdt_addr}, 32'd3);
    chk("chain_regwrite_t", {31'd0, regwrite_t}, 32'd1);
    fowardAE = 2'b10; fowardBE = 2'b01; #1;
    chk("fwd_a_m", operand_a, 32'h33);
    chk("fwd_b_w", operand_b, 32'h22);
    fowardAE = 2'b11; fowardBE = 2'b00; #1;
    chk("fwd_a_t", operand_a, 32'h11);
    chk("fwd_b_rf", operand_b, 32'h0000_ABCD);
    fowardAE = 2'b00; fowardBE = 2'b11; #1;
    chk("fwd_a_rf", operand_a, 32'h1111_0000);
    chk("fwd_b_t", operand_b, 32'h11);
    fowardBE = 2'b00;
    tick(); tick();

    // load: address in M, loaded word from W on
    dmem_rdata = 32'hDEAD_BEEF;
    issue(5'd7, 1'b1, 1'b1, 32'h1000); tick();
    fowardAE = 2'b10; #1;
    chk("ld_fwd_m_addr", operand_a, 32'h1000);
    issue(5'd0, 1'b0, 1'b0, 32'h0); tick();
    chk("ld_rf_wr_data", rf_wr_data, 32'hDEAD_BEEF);
    fowardAE = 2'b01; #1;
    chk("ld_fwd_w", operand_a, 32'hDEAD_BEEF);
    fowardAE = 2'b00;

    // write to x0 is normalised away
    issue(5'd0, 1'b1, 1'b0, 32'hFFFF); tick();
    chk("x0_regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("x0_rdm_addr", {27'd0, rdm_addr}, 32'd0);
    issue(5'd0, 1'b0, 1'b0, 32'h0); tick();
    chk("x0_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);

    // flush while stalled: M dies, W holds
    issue(5'd8, 1'b1, 1'b0, 32'h88); tick();
    issue(5'd9, 1'b1, 1'b0, 32'h99); tick();
    chk("fl_rdm_x9", {27'd0, rdm_addr}, 32'd9);
    issue(5'd0, 1'b0, 1'b0, 32'h0);
    advance_en = 1'b0; flush_m = 1'b1;
    if (sb.size() > 0) void'(sb.pop_back());
    tick();
    chk("fl_stall_regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("fl_stall_rdm", {27'd0, rdm_addr}, 32'd0);
    chk("fl_stall_rdw", {27'd0, rdw_addr}, 32'd8);
    chk("fl_stall_regwrite_w", {31'd0, regwrite_w}, 32'd1);
    chk("fl_stall_rf_wr_data", rf_wr_data, 32'h88);

    // flush while advancing: old M goes to W, EX is dropped
    flush_m = 1'b0; advance_en = 1'b1;
    issue(5'd10, 1'b1, 1'b0, 32'hA0); tick();
    chk("fl_adv_rdt_x8", {27'd0, rdt_addr}, 32'd8);
    flush_m = 1'b1;
    issue(5'd11, 1'b1, 1'b0, 32'hB0); tick();
    flush_m = 1'b0;
    chk("fl_adv_rdm", {27'd0, rdm_addr}, 32'd0);
    chk("fl_adv_regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("fl_adv_rdw", {27'd0, rdw_addr}, 32'd10);
    chk("fl_adv_regwrite_w", {31'd0, regwrite_w}, 32'd1);

    // hold for three cycles with x6 waiting in EX
    advance_en = 1'b0;
    issue(5'd6, 1'b1, 1'b0, 32'h66);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_rdm", {27'd0, rdm_addr}, 32'd0);
      chk("hold_rdw", {27'd0, rdw_addr}, 32'd10);
      chk("hold_rf_wr_en", {31'd0, rf_wr_en}, 32'd1);
      chk("hold_rf_wr_data", rf_wr_data, 32'hA0);
    end
    advance_en = 1'b1; tick();
    chk("hold_rel_rdm", {27'd0, rdm_addr}, 32'd6);
    fowardAE = 2'b10; #1;
    chk("hold_rel_fwd_m", operand_a, 32'h66);
    fowardAE = 2'b00;
    issue(5'd0, 1'b0, 1'b0, 32'h0); tick(); tick();

    // async reset mid-stream
    issue(5'd13, 1'b1, 1'b0, 32'hD0); tick();
    issue(5'd0, 1'b0, 1'b0, 32'h0); tick();
    chk("mid_pre_regwrite_w", {31'd0, regwrite_w}, 32'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("mid_rst_regwrite_w", {31'd0, regwrite_w}, 32'd0);
    chk("mid_rst_regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("mid_rst_rdw", {27'd0, rdw_addr}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
